// File: rtl/bp_cac_req_responder_if.sv
// Request/response link bundle for the coherence-NoC responder.
// The responder sits on the slave side: it consumes requests and produces responses.
interface bp_cac_req_responder_if #(
    parameter int flit_width_p = 64
);
    logic                    req_v;
    logic [flit_width_p-1:0] req_data;
    logic                    req_ready_and;
    logic                    cmd_v;
    logic [flit_width_p-1:0] cmd_data;
    logic                    cmd_ready_and;

    modport master (
        output req_v, req_data,
        input  req_ready_and,
        input  cmd_v, cmd_data,
        output cmd_ready_and
    );

    modport slave (
        input  req_v, req_data,
        output req_ready_and,
        output cmd_v, cmd_data,
        input  cmd_ready_and
    );
endinterface

// File: rtl/bp_cac_req_responder.sv
// Coherence-NoC far-end responder: takes one request packet, then echoes its body
// back to the requesting tile behind a response header.
module bp_cac_req_responder #(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4,
    parameter int max_body_p   = 8
) (
    input  logic                    coh_clk_i,
    input  logic                    coh_reset_n_i,
    input  logic [cord_width_p-1:0] my_cord_i,
    bp_cac_req_responder_if.slave   link,
    output logic                    busy_o,
    output logic [15:0]             pkt_count_o
);
    localparam int TAG_W = flit_width_p - 1 - 2*cord_width_p - len_width_p;
    localparam int IDX_W = (max_body_p > 1) ? $clog2(max_body_p) : 1;
    localparam logic [len_width_p:0]   MAX_BODY = (len_width_p+1)'(max_body_p);
    localparam logic [len_width_p-1:0] LEN_ONE  = len_width_p'(1);

    if (max_body_p < 1 || max_body_p > (2**len_width_p) - 1) begin : g_bad_depth
        $error("max_body_p must lie in 1 .. 2**len_width_p-1");
    end

    typedef struct packed {
        logic                    err;
        logic [TAG_W-1:0]        tag;
        logic [cord_width_p-1:0] src;
        logic [len_width_p-1:0]  len;
        logic [cord_width_p-1:0] dst;
    } hdr_t;

    typedef enum logic [1:0] {IDLE, RECV, SEND_HDR, SEND_BODY} state_e;

    state_e                  state_q, state_n;
    hdr_t                    req_hdr, rsp_hdr;
    logic [cord_width_p-1:0] src_q;
    logic [len_width_p-1:0]  len_q, cnt_q, idx_q, rlen;
    logic [TAG_W-1:0]        tag_q;
    logic                    err_q, busy_q;
    logic [15:0]             pkt_count_q, pkt_count_n;
    logic [flit_width_p-1:0] body_q [max_body_p];
    logic                    req_hs, cmd_hs, body_wr, rsp_done;
    logic                    unused_hdr;

    assign req_hdr    = hdr_t'(link.req_data);
    // Incoming dst is always us and the incoming error flag has no meaning here.
    assign unused_hdr = ^{req_hdr.err, req_hdr.dst};

    assign req_hs  = link.req_v & link.req_ready_and;
    assign cmd_hs  = link.cmd_v & link.cmd_ready_and;
    assign body_wr = (state_q == RECV) && req_hs && ({1'b0, cnt_q} < MAX_BODY);
    assign rlen    = err_q ? '0 : len_q;

    always_comb begin
        rsp_hdr     = '0;
        rsp_hdr.err = err_q;
        rsp_hdr.tag = tag_q;
        rsp_hdr.src = my_cord_i;
        rsp_hdr.len = rlen;
        rsp_hdr.dst = src_q;
    end

    always_comb begin
        state_n            = state_q;
        link.req_ready_and = 1'b0;
        link.cmd_v         = 1'b0;
        link.cmd_data      = '0;
        rsp_done           = 1'b0;
        unique case (state_q)
            IDLE: begin
                link.req_ready_and = 1'b1;
                if (link.req_v)
                    state_n = (req_hdr.len == '0) ? SEND_HDR : RECV;
            end
            RECV: begin
                link.req_ready_and = 1'b1;
                if (link.req_v && cnt_q == len_q - LEN_ONE)
                    state_n = SEND_HDR;
            end
            SEND_HDR: begin
                link.cmd_v    = 1'b1;
                link.cmd_data = rsp_hdr;
                if (link.cmd_ready_and) begin
                    if (rlen == '0) begin
                        state_n  = IDLE;
                        rsp_done = 1'b1;
                    end else begin
                        state_n = SEND_BODY;
                    end
                end
            end
            SEND_BODY: begin
                link.cmd_v    = 1'b1;
                link.cmd_data = body_q[idx_q[IDX_W-1:0]];
                if (link.cmd_ready_and && idx_q == rlen - LEN_ONE) begin
                    state_n  = IDLE;
                    rsp_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign pkt_count_n = pkt_count_q + {15'd0, rsp_done};

    always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
        if (!coh_reset_n_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            pkt_count_q <= '0;
            src_q       <= '0;
            len_q       <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_n;
            busy_q      <= (state_n != IDLE);
            pkt_count_q <= pkt_count_n;
            if (state_q == IDLE && req_hs) begin
                src_q <= req_hdr.src;
                len_q <= req_hdr.len;
                tag_q <= req_hdr.tag;
                err_q <= 1'b0;
                cnt_q <= '0;
            end else if (state_q == RECV && req_hs) begin
                cnt_q <= cnt_q + LEN_ONE;
                // Flits past the buffer are drained but poison the response.
                if (!body_wr)
                    err_q <= 1'b1;
            end
            if (state_q == SEND_HDR && cmd_hs)
                idx_q <= '0;
            else if (state_q == SEND_BODY && cmd_hs)
                idx_q <= idx_q + LEN_ONE;
        end
    end

    // Body storage needs no reset; it is always written before it is read.
    always_ff @(posedge coh_clk_i) begin
        if (body_wr)
            body_q[cnt_q[IDX_W-1:0]] <= link.req_data;
    end

    assign busy_o      = busy_q;
    assign pkt_count_o = pkt_count_q;
endmodule
